trng_ctrl: RTL and testbench
============================

TRNG_CTRL -- requirements
Module: trng_ctrl

Interface
REQ-001 Parameter N, default 30, number of ring-oscillator outputs sampled.
REQ-002 Parameter WARMUP, default 64, cycles ROs run after enable before the first sample (>=1).
REQ-003 Parameter SAMPLE_DIV, default 8, cycles per sampled bit (>=1).
REQ-004 Parameter REP_LIMIT, default 32, consecutive identical raw bits that declare a health fault (2..255).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 CLK  in  1  system clock; all state updates on its rising edge.
REQ-007 RST  in  1  asynchronous active-high reset.
REQ-008 START  in  1  level request for random bytes; sampled in IDLE and at the PRESENT handshake.
REQ-009 RO_IN  in  N  raw RO outputs, asynchronous to CLK.
REQ-010 READY  in  1  consumer accepts DATA when READY and VALID are both high.
REQ-011 CLR_FAIL  in  1  clears the fault condition; ignored outside FAULT.
REQ-012 RO_EN  out  1  RO bank enable.
REQ-013 DATA  out  8  random byte; stable while VALID is high.
REQ-014 VALID  out  1  DATA available.
REQ-015 BUSY  out  1  high in WARMUP, SAMPLE and PRESENT.
REQ-016 FAIL  out  1  high only in FAULT.

Function
REQ-017 Each RO_IN bit SHALL pass through a 2-flop synchronizer; the raw bit is the XOR reduction of all N synchronized bits.
REQ-018 FSM states: IDLE, WARMUP, SAMPLE, PRESENT, FAULT.
REQ-019 IDLE: RO_EN=0, VALID=0. START=1 -> WARMUP, RO_EN=1, cycle counter cleared.
REQ-020 WARMUP: after exactly WARMUP cycles -> SAMPLE; no bits are captured.
REQ-021 SAMPLE: a raw bit is captured on the last cycle of each SAMPLE_DIV window and shifted into an 8-bit register at the LSB (shift left); the first captured bit ends as DATA[7].
REQ-022 After the 8th capture, DATA SHALL load the shift register and VALID=1 on the same edge as the transition to PRESENT.
REQ-023 Latency: taking edge 0 as the one where START moves IDLE->WARMUP, VALID SHALL rise at edge WARMUP+8*SAMPLE_DIV.
REQ-024 PRESENT: no captures; DATA and VALID held until READY=1.
REQ-025 On the VALID&READY edge: VALID=0. If START=1 -> SAMPLE with RO_EN kept at 1 and no warmup. Otherwise -> IDLE with RO_EN=0.
REQ-026 Repetition test: a counter tracks run length of identical consecutive captured bits and continues across byte boundaries. It resets to 1 on RO enable from IDLE.
REQ-027 When the run length reaches REP_LIMIT: -> FAULT on that edge; the byte under construction is discarded.
REQ-028 FAULT: FAIL=1, RO_EN=0, VALID=0, BUSY=0. START is ignored. CLR_FAIL=1 -> IDLE with FAIL=0 on the next edge.
REQ-029 START deasserting during WARMUP or SAMPLE SHALL NOT abort the current byte.
REQ-030 Counters SHALL be sized as clog2 of their limit plus 1 and SHALL NOT wrap within a state.

Reset
REQ-031 RST=1 SHALL immediately force IDLE and set the following to 0: RO_EN, DATA, VALID, BUSY, FAIL, synchronizers, shift register and all counters.
REQ-032 Reset asserted mid-operation SHALL discard any partial byte; after RST falls, the block behaves as from power-up.

Structure
REQ-033 Package trng_pkg SHALL hold the FSM state enumeration and the default values of N, WARMUP, SAMPLE_DIV and REP_LIMIT.
REQ-034 Sub-module trng_sync SHALL implement the parameterized-width 2-flop synchronizer; all remaining logic resides in trng_ctrl.

Verification
Bench parameters: N=4, WARMUP=4, SAMPLE_DIV=2, REP_LIMIT=8. RO_IN is driven 2 cycles ahead to cover synchronizer delay.
REQ-035 Reset: RST pulse at any point -> all outputs 0 within the same cycle; the FSM is in IDLE.
REQ-036 Known pattern: START pulse, XOR sequence 1,0,1,1,0,0,1,0 -> VALID rises at edge 20 with DATA=8'hB2, RO_EN=1 from edge 0.
REQ-037 Backpressure: READY held low for 10 cycles -> DATA=8'hB2 and VALID stay stable with no captures. READY=1 with START=1 -> next byte VALID 16 cycles later, and RO_EN never drops.
REQ-038 Stuck source: RO_IN XOR constant 0 -> FAULT at the 8th capture (edge 4+16=20), FAIL=1, RO_EN=0, VALID never asserts. START ignored. CLR_FAIL -> IDLE with FAIL=0.
REQ-039 Reset mid-SAMPLE after 5 captures -> outputs 0 at once; a new START yields a full 8-capture byte timed per REQ-023.
REQ-040 Cross-byte run: the last 4 bits of byte 1 and the first 4 bits of byte 2 are all 1 -> FAULT at the 4th capture of byte 2.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator TRNG controller.
// Holds the FSM state type and the default parameter values.
// Latency/backpressure: n/a (definitions only).
package trng_pkg;

  localparam int N_DEF          = 30;
  localparam int WARMUP_DEF     = 64;
  localparam int SAMPLE_DIV_DEF = 8;
  localparam int REP_LIMIT_DEF  = 32;

  // Bits collected per output byte.
  localparam int BYTE_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/trng_if.sv
// Request/response bundle between a random-byte consumer and trng_ctrl.
// Latency: none (wires only).
// Backpressure: data/valid held by the controller until ready.
// Ports: start, ready, clr_fail (consumer -> controller);
//        ro_en, data, valid, busy, fail (controller -> consumer).
interface trng_if;

  logic       start;
  logic       ready;
  logic       clr_fail;
  logic       ro_en;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       fail;

  // Consumer side.
  modport master (
    output start, ready, clr_fail,
    input  ro_en, data, valid, busy, fail
  );

  // Controller side.
  modport slave (
    input  start, ready, clr_fail,
    output ro_en, data, valid, busy, fail
  );

endinterface

// File: rtl/trng_sync.sv
// Parameterized-width 2-flop synchronizer for asynchronous RO outputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk, rst (async active-high), d[W] async input, q[W] synchronized output.
module trng_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG controller: warm up ROs, sample XOR of bank into bytes, repetition health test.
// Latency: first byte valid WARMUP + 8*SAMPLE_DIV edges after start; back-to-back bytes 8*SAMPLE_DIV.
// Backpressure: byte held in PRESENT (no sampling) until ready; start at handshake chains next byte.
// Ports: clk, rst (async active-high), ro_in[N] raw RO outputs, host (trng_if.slave).
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int WARMUP     = WARMUP_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ro_in,
  trng_if.slave        host
);

  // One cycle counter serves both the warmup period and the sample window.
  localparam int CNT_MAX = (WARMUP > SAMPLE_DIV) ? WARMUP : SAMPLE_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BIT_W   = $clog2(BYTE_BITS) + 1;
  localparam int REP_W   = $clog2(REP_LIMIT) + 1;

  logic [N-1:0]     ro_sync;
  logic             raw_bit;

  state_t           state;
  logic             ro_en_q;
  logic             valid_q;
  logic             busy_q;
  logic             fail_q;
  logic [7:0]       data_q;
  logic [7:0]       shift_q;
  logic [CNT_W-1:0] cyc_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             last_bit;
  logic             have_bit;

  logic [REP_W-1:0] rep_next;
  logic [7:0]       shift_next;
  logic             warm_done;
  logic             win_end;

  trng_sync #(.W(N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ro_in),
    .q   (ro_sync)
  );

  assign raw_bit = ^ro_sync;

  // Run length after the current capture; the first bit after enable has no predecessor.
  assign rep_next   = (have_bit && (raw_bit == last_bit)) ? rep_cnt + REP_W'(1) : REP_W'(1);
  assign shift_next = {shift_q[6:0], raw_bit};
  assign warm_done  = (cyc_cnt == CNT_W'(WARMUP - 1));
  assign win_end    = (cyc_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ro_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      fail_q   <= 1'b0;
      data_q   <= 8'd0;
      shift_q  <= 8'd0;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      last_bit <= 1'b0;
      have_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.start) begin
            state    <= ST_WARMUP;
            ro_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            shift_q  <= 8'd0;
            rep_cnt  <= REP_W'(1);
            have_bit <= 1'b0;
          end
        end

        ST_WARMUP: begin
          if (warm_done) begin
            state   <= ST_SAMPLE;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (win_end) begin
            cyc_cnt  <= '0;
            rep_cnt  <= rep_next;
            last_bit <= raw_bit;
            have_bit <= 1'b1;
            if (rep_next == REP_W'(REP_LIMIT)) begin
              // Health fault wins over byte completion; partial byte dropped.
              state   <= ST_FAULT;
              ro_en_q <= 1'b0;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
              shift_q <= 8'd0;
              bit_cnt <= '0;
            end else if (bit_cnt == BIT_W'(BYTE_BITS - 1)) begin
              state   <= ST_PRESENT;
              data_q  <= shift_next;
              valid_q <= 1'b1;
              shift_q <= 8'd0;
              bit_cnt <= '0;
            end else begin
              shift_q <= shift_next;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end

        ST_PRESENT: begin
          if (host.ready) begin
            valid_q <= 1'b0;
            cyc_cnt <= '0;
            if (host.start) begin
              // Chain straight into the next byte; ROs are already settled.
              state <= ST_SAMPLE;
            end else begin
              state   <= ST_IDLE;
              ro_en_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end

        ST_FAULT: begin
          if (host.clr_fail) begin
            state  <= ST_IDLE;
            fail_q <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          ro_en_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          fail_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host.ro_en = ro_en_q;
  assign host.data  = data_q;
  assign host.valid = valid_q;
  assign host.busy  = busy_q;
  assign host.fail  = fail_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Self-checking bench for trng_ctrl: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a timestamp-based behavioural model.
// Ports: none (top-level bench).
module tb_trng_ctrl;

  localparam int N   = 4;
  localparam int WU  = 4;
  localparam int SD  = 2;
  localparam int RL  = 8;
  localparam int PSZ = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ro_in = '0;

  trng_if bus_if ();

  trng_ctrl #(
    .N          (N),
    .WARMUP     (WU),
    .SAMPLE_DIV (SD),
    .REP_LIMIT  (RL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ro_in (ro_in),
    .host  (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // plan[e] = parity the bank must show for a capture at edge e.
  bit plan [PSZ];

  typedef enum int {M_IDLE, M_WARM, M_SAMP, M_PRES, M_FAULT} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_next = 0;
  int         m_nbits = 0;
  int         m_run = 0;
  bit         m_have = 1'b0;
  bit         m_last = 1'b0;
  bit         m_p1 = 1'b0;
  bit         m_p2 = 1'b0;
  logic [7:0] m_acc = 8'd0;
  logic [7:0] m_data = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic to_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic plan_byte(input int e, input logic [7:0] b);
    for (int k = 0; k < 8; k++) plan[(e + 2 * k) % PSZ] = b[7-k];
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: events scheduled by absolute edge number.
  always @(posedge clk or posedge rst) begin : model
    int now;
    bit raw;
    if (rst) begin
      m_mode = M_IDLE;
      m_p1   = 1'b0;
      m_p2   = 1'b0;
      m_data = 8'd0;
      m_acc  = 8'd0;
      m_have = 1'b0;
      m_run  = 0;
    end else begin
      now  = cyc + 1;
      raw  = m_p2;
      m_p2 = m_p1;
      m_p1 = ^ro_in;
      case (m_mode)
        M_IDLE: if (bus_if.start) begin
          m_mode  = M_WARM;
          m_next  = now + WU;
          m_nbits = 0;
          m_have  = 1'b0;
          m_run   = 0;
        end
        M_WARM: if (now == m_next) begin
          m_mode = M_SAMP;
          m_next = now + SD;
        end
        M_SAMP: if (now == m_next) begin
          m_run  = (m_have && raw == m_last) ? m_run + 1 : 1;
          m_have = 1'b1;
          m_last = raw;
          m_acc  = {m_acc[6:0], raw};
          m_nbits++;
          if (m_run >= RL) m_mode = M_FAULT;
          else if (m_nbits == 8) begin
            m_data = m_acc;
            m_mode = M_PRES;
          end else m_next = now + SD;
        end
        M_PRES: if (bus_if.ready) begin
          if (bus_if.start) begin
            m_mode  = M_SAMP;
            m_nbits = 0;
            m_next  = now + SD;
          end else m_mode = M_IDLE;
        end
        M_FAULT: if (bus_if.clr_fail) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    bit act_ph;
    act_ph = (m_mode == M_WARM) || (m_mode == M_SAMP) || (m_mode == M_PRES);
    chk("m.ro_en", 32'(bus_if.ro_en), 32'(act_ph));
    chk("m.busy",  32'(bus_if.busy),  32'(act_ph));
    chk("m.valid", 32'(bus_if.valid), 32'(m_mode == M_PRES));
    chk("m.fail",  32'(bus_if.fail),  32'(m_mode == M_FAULT));
    chk("m.data",  32'(bus_if.data),  32'(m_data));
  end

  // RO driver: value sampled at edge c+1 is captured at edge c+3.
  always @(negedge clk) begin : drv
    logic [N-1:0] v;
    #1;
    v     = N'($urandom);
    v[0]  = v[0] ^ (^v) ^ plan[(cyc + 3) % PSZ];
    ro_in = v;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e0;
    int e1;
    int drops;
    for (int i = 0; i < PSZ; i++) plan[i] = 1'($urandom_range(0, 1));
    bus_if.start    = 1'b0;
    bus_if.ready    = 1'b0;
    bus_if.clr_fail = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst ro_en", 32'(bus_if.ro_en), 32'd0);
    chk("rst valid", 32'(bus_if.valid), 32'd0);
    chk("rst busy",  32'(bus_if.busy),  32'd0);
    chk("rst fail",  32'(bus_if.fail),  32'd0);
    chk("rst data",  32'(bus_if.data),  32'd0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known pattern 1,0,1,1,0,0,1,0 then backpressure and chained byte.
    e0 = cyc + 1;
    plan_byte(e0 + 6, 8'hB2);
    plan_byte(e0 + 33, 8'h6D);
    bus_if.start = 1'b1;
    to_edge(e0);
    bus_if.start = 1'b0;
    chk("A ro_en edge0", 32'(bus_if.ro_en), 32'd1);
    to_edge(e0 + 19);
    chk("A valid edge19", 32'(bus_if.valid), 32'd0);
    to_edge(e0 + 20);
    chk("A valid edge20", 32'(bus_if.valid), 32'd1);
    chk("A data edge20", 32'(bus_if.data), 32'hB2);
    drops = 0;
    for (int k = 1; k <= 10; k++) begin
      to_edge(e0 + 20 + k);
      chk("A hold valid", 32'(bus_if.valid), 32'd1);
      chk("A hold data", 32'(bus_if.data), 32'hB2);
      if (bus_if.ro_en !== 1'b1) drops++;
    end
    bus_if.ready = 1'b1;
    bus_if.start = 1'b1;
    to_edge(e0 + 31);
    chk("A valid after hs", 32'(bus_if.valid), 32'd0);
    bus_if.start = 1'b0;
    for (int e = e0 + 31; e <= e0 + 46; e++) begin
      to_edge(e);
      if (bus_if.ro_en !== 1'b1) drops++;
    end
    chk("A ro_en drops", 32'(drops), 32'd0);
    chk("A valid edge46", 32'(bus_if.valid), 32'd0);
    to_edge(e0 + 47);
    chk("A valid edge47", 32'(bus_if.valid), 32'd1);
    chk("A data edge47", 32'(bus_if.data), 32'h6D);
    to_edge(e0 + 48);
    chk("A idle ro_en", 32'(bus_if.ro_en), 32'd0);

    // Stuck source: parity constant 0.
    @(negedge clk);
    e0 = cyc + 1;
    for (int k = 0; k <= 30; k++) plan[(e0 + k) % PSZ] = 1'b0;
    bus_if.start = 1'b1;
    to_edge(e0 + 19);
    chk("B fail edge19", 32'(bus_if.fail), 32'd0);
    chk("B ro_en edge19", 32'(bus_if.ro_en), 32'd1);
    to_edge(e0 + 20);
    chk("B fail edge20", 32'(bus_if.fail), 32'd1);
    chk("B ro_en edge20", 32'(bus_if.ro_en), 32'd0);
    chk("B valid edge20", 32'(bus_if.valid), 32'd0);
    chk("B busy edge20", 32'(bus_if.busy), 32'd0);
    to_edge(e0 + 23);
    chk("B start ignored", 32'(bus_if.fail), 32'd1);
    bus_if.clr_fail = 1'b1;
    bus_if.start    = 1'b0;
    to_edge(e0 + 24);
    chk("B cleared fail", 32'(bus_if.fail), 32'd0);
    chk("B cleared busy", 32'(bus_if.busy), 32'd0);
    bus_if.clr_fail = 1'b0;

    // Reset after 5 captures, then a clean byte.
    @(negedge clk);
    e0 = cyc + 1;
    plan_byte(e0 + 6, 8'h5C);
    bus_if.start = 1'b1;
    to_edge(e0);
    bus_if.start = 1'b0;
    to_edge(e0 + 14);
    #2 rst = 1'b1;
    #1;
    chk("C rst ro_en", 32'(bus_if.ro_en), 32'd0);
    chk("C rst busy",  32'(bus_if.busy),  32'd0);
    chk("C rst valid", 32'(bus_if.valid), 32'd0);
    chk("C rst data",  32'(bus_if.data),  32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    e1 = cyc + 1;
    plan_byte(e1 + 6, 8'h5C);
    bus_if.start = 1'b1;
    to_edge(e1);
    bus_if.start = 1'b0;
    to_edge(e1 + 19);
    chk("C valid edge19", 32'(bus_if.valid), 32'd0);
    to_edge(e1 + 20);
    chk("C valid edge20", 32'(bus_if.valid), 32'd1);
    chk("C data edge20", 32'(bus_if.data), 32'h5C);
    to_edge(e1 + 22);

    // Run of ones spanning the byte boundary.
    @(negedge clk);
    e0 = cyc + 1;
    plan_byte(e0 + 6, 8'hAF);
    for (int k = 0; k < 4; k++) plan[(e0 + 23 + 2 * k) % PSZ] = 1'b1;
    bus_if.start = 1'b1;
    bus_if.ready = 1'b1;
    to_edge(e0 + 20);
    chk("D data byte1", 32'(bus_if.data), 32'hAF);
    chk("D valid byte1", 32'(bus_if.valid), 32'd1);
    to_edge(e0 + 28);
    chk("D fail edge28", 32'(bus_if.fail), 32'd0);
    to_edge(e0 + 29);
    chk("D fail edge29", 32'(bus_if.fail), 32'd1);
    chk("D ro_en edge29", 32'(bus_if.ro_en), 32'd0);
    bus_if.start    = 1'b0;
    bus_if.clr_fail = 1'b1;
    to_edge(e0 + 30);
    chk("D cleared", 32'(bus_if.fail), 32'd0);
    bus_if.clr_fail = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      rst             = ($urandom_range(0, 299) == 0);
      bus_if.start    = ($urandom_range(0, 3) == 0);
      bus_if.ready    = ($urandom_range(0, 2) != 0);
      bus_if.clr_fail = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
